// File: rtl/rv32i_instruction_fetch.sv
// RV32I instruction fetch: PC, instruction-memory read initiator, decode handshake.
// Optional FETCH_ALIGN_CHECK_EN traps misaligned redirect targets in FAULT.
module rv32i_instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_mem_rd_en,
  output logic [31:0] o_mem_rd_addr,
  input  logic [31:0] i_mem_rd_data,
  input  logic        i_mem_rd_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  output logic        o_instr_valid,
  input  logic        i_instr_ready,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_fetch_fault
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_HOLD,
    S_FLUSH,
    S_FAULT
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc;
  logic [31:0] pc_nxt;
  logic [31:0] tgt;
  logic        tgt_bad;
  logic        capture;
  logic        rd_en_nxt;
  logic        valid_nxt;
  logic        fault_nxt;

`ifdef FETCH_ALIGN_CHECK_EN
  assign tgt     = i_redirect_pc;
  assign tgt_bad = |i_redirect_pc[1:0];
`else
  assign tgt     = i_redirect_pc & 32'hFFFF_FFFC;
  assign tgt_bad = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= S_IDLE;
      pc            <= RESET_PC;
      o_mem_rd_en   <= 1'b0;
      o_instr_valid <= 1'b0;
      o_fetch_fault <= 1'b0;
      o_instr       <= 32'h0;
      o_pc          <= RESET_PC;
    end else begin
      state         <= state_nxt;
      pc            <= pc_nxt;
      o_mem_rd_en   <= rd_en_nxt;
      o_instr_valid <= valid_nxt;
      o_fetch_fault <= fault_nxt;
      if (capture) begin
        o_instr <= i_mem_rd_data;
        o_pc    <= pc;
      end
    end
  end

  // Redirect outranks every response and handshake outside IDLE
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: state_nxt = S_REQ;
      S_REQ: begin
        if (i_redirect)
          state_nxt = tgt_bad ? S_FAULT : S_FLUSH;
        else if (i_mem_rd_valid)
          state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (i_redirect)
          state_nxt = tgt_bad ? S_FAULT : S_REQ;
        else if (i_instr_ready)
          state_nxt = S_REQ;
      end
      S_FLUSH: begin
        if (i_redirect && tgt_bad)
          state_nxt = S_FAULT;
        else
          state_nxt = S_REQ;
      end
      S_FAULT: begin
        if (i_redirect && !tgt_bad)
          state_nxt = S_REQ;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    pc_nxt    = pc;
    capture   = 1'b0;
    rd_en_nxt = (state_nxt == S_REQ);
    valid_nxt = (state_nxt == S_HOLD);
    fault_nxt = (state_nxt == S_FAULT);
    if (state != S_IDLE && i_redirect)
      pc_nxt = tgt;
    else if (state == S_HOLD && i_instr_ready)
      pc_nxt = pc + 32'd4;
    if (state == S_REQ && i_mem_rd_valid && !i_redirect)
      capture = 1'b1;
  end

  assign o_mem_rd_addr = pc;

endmodule

// File: tb/tb_rv32i_instruction_fetch.sv
// Bench for rv32i_instruction_fetch: directed scenarios plus a randomized
// run against a transaction-level PC model and a variable-latency memory.
module tb_rv32i_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_rd_en;
  logic [31:0] mem_rd_addr;
  logic [31:0] mem_rd_data = 32'h0;
  logic        mem_rd_valid = 1'b0;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        fetch_fault;

  int checks = 0;
  int errors = 0;

  int mem_cnt = 0;
  int mem_lat = 2;
  int fixed_lat = 2;
  bit mem_rand = 1'b0;

  always #5 clk = ~clk;

  rv32i_instruction_fetch dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .o_mem_rd_en    (mem_rd_en),
    .o_mem_rd_addr  (mem_rd_addr),
    .i_mem_rd_data  (mem_rd_data),
    .i_mem_rd_valid (mem_rd_valid),
    .o_instr        (instr),
    .o_pc           (pc),
    .o_instr_valid  (instr_valid),
    .i_instr_ready  (instr_ready),
    .i_redirect     (redirect),
    .i_redirect_pc  (redirect_pc),
    .o_fetch_fault  (fetch_fault)
  );

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return 32'h0000_0013 + (a >> 2);
  endfunction

  // Memory: answers after mem_lat cycles of continuous rd_en
  always @(posedge clk) begin
    #1;
    if (mem_rd_valid) begin
      mem_rd_valid = 1'b0;
      mem_rd_data  = $urandom;
      mem_cnt      = 0;
    end else if (rst || !mem_rd_en) begin
      mem_cnt = 0;
    end else begin
      if (mem_cnt == 0)
        mem_lat = mem_rand ? $urandom_range(1, 4) : fixed_lat;
      mem_cnt++;
      if (mem_cnt >= mem_lat) begin
        mem_rd_valid = 1'b1;
        mem_rd_data  = word_at(mem_rd_addr);
      end
    end
  end

  task automatic do_reset();
    rst         = 1'b1;
    redirect    = 1'b0;
    instr_ready = 1'b0;
    mem_rand    = 1'b0;
    fixed_lat   = 2;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      redirect = 1'b0;
      if (instr_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (mem_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_rd_en got %b exp 0", mem_rd_en);
    end
    checks++;
    if (mem_rd_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_addr got %h exp 0", mem_rd_addr);
    end
    checks++;
    if (instr !== 32'h0 || pc !== 32'h0) begin
      errors++;
      $display("FAIL reset_instr_pc got %h/%h exp 0/0", instr, pc);
    end
    checks++;
    if (instr_valid !== 1'b0 || fetch_fault !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got %b%b exp 00",
               instr_valid, fetch_fault);
    end
  endtask

  task automatic test_stream();
    bit          ev;
    logic [31:0] ep;
    do_reset();
    instr_ready = 1'b1;
    checks++;
    if (mem_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL stream_idle_rd_en got %b exp 0", mem_rd_en);
    end
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      ev = (k % 3 == 0);
      checks++;
      if (instr_valid !== ev || mem_rd_en !== !ev) begin
        errors++;
        $display("FAIL stream_k%0d valid/rd_en got %b%b exp %b%b",
                 k, instr_valid, mem_rd_en, ev, !ev);
      end
      if (ev) begin
        ep = 32'(4 * (k / 3 - 1));
        checks++;
        if (pc !== ep || instr !== word_at(ep)) begin
          errors++;
          $display("FAIL stream_data pc/instr got %h/%h exp %h/%h",
                   pc, instr, ep, word_at(ep));
        end
      end else begin
        ep = 32'(4 * (k / 3));
        checks++;
        if (mem_rd_addr !== ep) begin
          errors++;
          $display("FAIL stream_addr got %h exp %h", mem_rd_addr, ep);
        end
      end
    end
  endtask

  task automatic test_stall();
    bit ok;
    do_reset();
    wait_valid(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL stall_wait got timeout exp valid");
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (instr_valid !== 1'b1 || mem_rd_en !== 1'b0 ||
          pc !== 32'h0 || instr !== word_at(32'h0)) begin
        errors++;
        $display("FAIL stall_hold v/rd/pc/instr got %b/%b/%h/%h exp 1/0/0/%h",
                 instr_valid, mem_rd_en, pc, instr, word_at(32'h0));
      end
    end
    instr_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (instr_valid !== 1'b0 || mem_rd_en !== 1'b1 ||
        mem_rd_addr !== 32'h4) begin
      errors++;
      $display("FAIL stall_release v/rd/addr got %b/%b/%h exp 0/1/4",
               instr_valid, mem_rd_en, mem_rd_addr);
    end
  endtask

  task automatic test_redirect_req(input int lat);
    bit ok;
    do_reset();
    fixed_lat   = lat;
    instr_ready = 1'b1;
    wait_valid(ok);
    wait_valid(ok);
    @(negedge clk);
    checks++;
    if (mem_rd_en !== 1'b1 || mem_rd_addr !== 32'h8) begin
      errors++;
      $display("FAIL rreq%0d_pre rd/addr got %b/%h exp 1/8",
               lat, mem_rd_en, mem_rd_addr);
    end
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    @(negedge clk);
    redirect = 1'b0;
    checks++;
    if (mem_rd_en !== 1'b0 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL rreq%0d_flush rd/v got %b/%b exp 0/0",
               lat, mem_rd_en, instr_valid);
    end
    @(negedge clk);
    checks++;
    if (mem_rd_en !== 1'b1 || mem_rd_addr !== 32'h100) begin
      errors++;
      $display("FAIL rreq%0d_req rd/addr got %b/%h exp 1/100",
               lat, mem_rd_en, mem_rd_addr);
    end
    wait_valid(ok);
    checks++;
    if (!ok || pc !== 32'h100 || instr !== word_at(32'h100)) begin
      errors++;
      $display("FAIL rreq%0d_deliver pc/instr got %h/%h exp 100/%h",
               lat, pc, instr, word_at(32'h100));
    end
  endtask

  task automatic test_redirect_accept();
    bit ok;
    do_reset();
    instr_ready = 1'b1;
    wait_valid(ok);
    wait_valid(ok);
    checks++;
    if (!ok || pc !== 32'h4) begin
      errors++;
      $display("FAIL racc_pre pc got %h exp 4", pc);
    end
    redirect    = 1'b1;
    redirect_pc = 32'h40;
    @(negedge clk);
    redirect = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || mem_rd_en !== 1'b1 ||
        mem_rd_addr !== 32'h40) begin
      errors++;
      $display("FAIL racc_next v/rd/addr got %b/%b/%h exp 0/1/40",
               instr_valid, mem_rd_en, mem_rd_addr);
    end
    wait_valid(ok);
    checks++;
    if (!ok || pc !== 32'h40) begin
      errors++;
      $display("FAIL racc_deliver pc got %h exp 40", pc);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    do_reset();
    instr_ready = 1'b1;
    wait_valid(ok);
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    wait_valid(ok);
    checks++;
    if (!ok || pc !== 32'hFFFF_FFFC ||
        instr !== word_at(32'hFFFF_FFFC)) begin
      errors++;
      $display("FAIL wrap_top pc/instr got %h/%h exp fffffffc/%h",
               pc, instr, word_at(32'hFFFF_FFFC));
    end
    @(negedge clk);
    checks++;
    if (mem_rd_en !== 1'b1 || mem_rd_addr !== 32'h0) begin
      errors++;
      $display("FAIL wrap_next rd/addr got %b/%h exp 1/0",
               mem_rd_en, mem_rd_addr);
    end
  endtask

  task automatic test_align();
    bit ok;
    do_reset();
    instr_ready = 1'b1;
    wait_valid(ok);
    @(negedge clk);
    redirect    = 1'b1;
    redirect_pc = 32'h102;
    @(negedge clk);
    redirect = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (fetch_fault !== 1'b1 || mem_rd_en !== 1'b0 ||
          instr_valid !== 1'b0) begin
        errors++;
        $display("FAIL align_fault f/rd/v got %b/%b/%b exp 1/0/0",
                 fetch_fault, mem_rd_en, instr_valid);
      end
      redirect = (i == 1);
      @(negedge clk);
      redirect = 1'b0;
    end
    redirect    = 1'b1;
    redirect_pc = 32'h104;
    @(negedge clk);
    redirect = 1'b0;
    checks++;
    if (fetch_fault !== 1'b0 || mem_rd_en !== 1'b1 ||
        mem_rd_addr !== 32'h104) begin
      errors++;
      $display("FAIL align_exit f/rd/addr got %b/%b/%h exp 0/1/104",
               fetch_fault, mem_rd_en, mem_rd_addr);
    end
    wait_valid(ok);
    checks++;
    if (!ok || pc !== 32'h104) begin
      errors++;
      $display("FAIL align_deliver pc got %h exp 104", pc);
    end
`else
    checks++;
    if (fetch_fault !== 1'b0 || mem_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL align_flush f/rd got %b/%b exp 0/0",
               fetch_fault, mem_rd_en);
    end
    @(negedge clk);
    checks++;
    if (mem_rd_en !== 1'b1 || mem_rd_addr !== 32'h100) begin
      errors++;
      $display("FAIL align_mask rd/addr got %b/%h exp 1/100",
               mem_rd_en, mem_rd_addr);
    end
    wait_valid(ok);
    checks++;
    if (!ok || pc !== 32'h100) begin
      errors++;
      $display("FAIL align_deliver pc got %h exp 100", pc);
    end
`endif
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    instr_ready = 1'b1;
    wait_valid(ok);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (mem_rd_valid !== 1'b1 || mem_rd_addr !== 32'h4) begin
      errors++;
      $display("FAIL rmid_pre mv/addr got %b/%h exp 1/4",
               mem_rd_valid, mem_rd_addr);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_rd_en !== 1'b0 || mem_rd_addr !== 32'h0 ||
        instr_valid !== 1'b0 || instr !== 32'h0 || pc !== 32'h0) begin
      errors++;
      $display("FAIL rmid_state rd/addr/v/instr/pc got %b/%h/%b/%h/%h exp 0/0/0/0/0",
               mem_rd_en, mem_rd_addr, instr_valid, instr, pc);
    end
    rst = 1'b0;
    wait_valid(ok);
    checks++;
    if (!ok || pc !== 32'h0) begin
      errors++;
      $display("FAIL rmid_restart pc got %h exp 0", pc);
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_pc;
    logic [31:0] tgt;
    bit          pv;
    bit          prd;
    bit          pr;
    int          n_acc;
    do_reset();
    mem_rand = 1'b1;
    exp_pc   = 32'h0;
    pv       = 1'b0;
    prd      = 1'b0;
    pr       = 1'b0;
    n_acc    = 0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      redirect = 1'b0;
      if (mem_rd_en) begin
        checks++;
        if (mem_rd_addr !== exp_pc) begin
          errors++;
          $display("FAIL rnd_addr got %h exp %h", mem_rd_addr, exp_pc);
        end
      end
      if (instr_valid) begin
        checks++;
        if (pc !== exp_pc || instr !== word_at(exp_pc)) begin
          errors++;
          $display("FAIL rnd_data pc/instr got %h/%h exp %h/%h",
                   pc, instr, exp_pc, word_at(exp_pc));
        end
      end
      checks++;
      if ((instr_valid && mem_rd_en) || fetch_fault !== 1'b0) begin
        errors++;
        $display("FAIL rnd_excl v/rd/f got %b/%b/%b exp no overlap, f=0",
                 instr_valid, mem_rd_en, fetch_fault);
      end
      if (pr) begin
        checks++;
        if (instr_valid !== 1'b0) begin
          errors++;
          $display("FAIL rnd_redir_valid got %b exp 0", instr_valid);
        end
        if (prd) begin
          checks++;
          if (mem_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL rnd_flush rd_en got %b exp 0", mem_rd_en);
          end
        end
        if (pv) begin
          checks++;
          if (mem_rd_en !== 1'b1) begin
            errors++;
            $display("FAIL rnd_hold_redir rd_en got %b exp 1", mem_rd_en);
          end
        end
      end
      instr_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) begin
        if ($urandom_range(0, 3) == 0)
          tgt = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4);
        else
          tgt = 32'($urandom_range(0, 1023) * 4);
`ifndef FETCH_ALIGN_CHECK_EN
        tgt[1:0] = 2'($urandom_range(0, 3));
`endif
        redirect    = 1'b1;
        redirect_pc = tgt;
      end
      pv  = instr_valid;
      prd = mem_rd_en;
      pr  = redirect;
      if (redirect) begin
        exp_pc = {redirect_pc[31:2], 2'b00};
      end else if (instr_valid && instr_ready) begin
        exp_pc = exp_pc + 32'd4;
        n_acc++;
      end
    end
    checks++;
    if (n_acc < 50) begin
      errors++;
      $display("FAIL rnd_progress got %0d accepts exp >= 50", n_acc);
    end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_req(2);
    test_redirect_req(1);
    test_redirect_accept();
    test_wrap();
    test_align();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
